// File: rtl/gray_codec.sv
// Clocked Gray-code unit: one-cycle binary-to-Gray encode and bit-serial Gray-to-binary decode.
// Optional saturating error counter on o_err_cnt is enabled by defining GRAY_ERR_CNT_EN.
module gray_codec #(
    parameter int LEN = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_mode,
    input  logic [LEN-1:0] i_data,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [LEN-1:0] o_data,
    output logic           o_err
`ifdef GRAY_ERR_CNT_EN
    ,
    output logic [7:0]     o_err_cnt
`endif
);

    localparam int KW = (LEN > 2) ? $clog2(LEN - 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_reg, state_next;
    logic [LEN-1:0] g_reg, g_next;
    logic [LEN-1:0] b_reg, b_next;
    logic [KW-1:0]  k_reg, k_next;
    logic [LEN-1:0] data_reg, data_next;
    logic           err_reg, err_next;
    logic [LEN-1:0] enc_word;

    // Gray bit i is the XOR of binary bits i and i+1; the MSB passes through.
    assign enc_word[LEN-1] = i_data[LEN-1];
    generate
        for (genvar gi = 0; gi < LEN - 1; gi++) begin : g_enc
            assign enc_word[gi] = i_data[gi] ^ i_data[gi+1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        b_next     = b_reg;
        k_next     = k_reg;
        data_next  = data_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    if (i_data[LEN-1]) begin
                        data_next  = '1;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else if (!i_mode) begin
                        data_next  = enc_word;
                        err_next   = 1'b0;
                        state_next = DONE;
                    end else begin
                        g_next          = i_data;
                        b_next          = '0;
                        b_next[LEN-1]   = i_data[LEN-1];
                        k_next          = KW'(LEN - 2);
                        state_next      = BUSY;
                    end
                end
            end
            BUSY: begin
                // One binary bit per cycle, walking from MSB-1 down to bit 0.
                for (int i = 0; i < LEN - 1; i++) begin
                    if (k_reg == KW'(i)) begin
                        b_next[i] = b_reg[i+1] ^ g_reg[i];
                    end
                end
                if (k_reg == '0) begin
                    data_next  = b_next;
                    err_next   = 1'b0;
                    state_next = DONE;
                end else begin
                    k_next = k_reg - 1'b1;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            g_reg     <= '0;
            b_reg     <= '0;
            k_reg     <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
            b_reg     <= b_next;
            k_reg     <= k_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

`ifdef GRAY_ERR_CNT_EN
    logic [7:0] cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE && i_valid && i_data[LEN-1] && cnt_reg != 8'hFF) begin
            cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign o_err_cnt = cnt_reg;
`endif

    assign o_ready = (state_reg == IDLE);
    assign o_valid = (state_reg == DONE);
    assign o_data  = data_reg;
    assign o_err   = err_reg;

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec (LEN = 4): directed and random words against a search-based reference model.
module tb_gray_codec;

    localparam int LEN = 4;

    logic           i_clk = 1'b0;
    logic           i_rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic           o_ready;
    logic           i_mode = 1'b0;
    logic [LEN-1:0] i_data = '0;
    logic           o_valid;
    logic           i_ready = 1'b0;
    logic [LEN-1:0] o_data;
    logic           o_err;
`ifdef GRAY_ERR_CNT_EN
    logic [7:0]     o_err_cnt;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cnt_model = 0;

    gray_codec #(.LEN(LEN)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_mode  (i_mode),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_err   (o_err)
`ifdef GRAY_ERR_CNT_EN
        ,
        .o_err_cnt (o_err_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: Gray of b is b ^ (b >> 1); decode finds the unique b producing g.
    function automatic logic [LEN-1:0] ref_enc(input logic [LEN-1:0] d);
        return d ^ (d >> 1);
    endfunction

    function automatic logic [LEN-1:0] ref_dec(input logic [LEN-1:0] g);
        logic [LEN-1:0] b;
        for (int n = 0; n < (1 << LEN); n++) begin
            b = LEN'(n);
            if (ref_enc(b) == g) return b;
        end
        return 'x;
    endfunction

    task automatic xact(input logic mode, input logic [LEN-1:0] d, input string tag);
        logic [LEN-1:0] exp_d;
        logic           exp_e;
        int             exp_lat;
        int             lat;
        if (d[LEN-1]) begin
            exp_d = '1; exp_e = 1'b1; exp_lat = 1;
            if (cnt_model < 255) cnt_model++;
        end else if (!mode) begin
            exp_d = ref_enc(d); exp_e = 1'b0; exp_lat = 1;
        end else begin
            exp_d = ref_dec(d); exp_e = 1'b0; exp_lat = LEN;
        end
        chk({tag, "_ready_in"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_mode = mode; i_data = d; i_ready = 1'b0;
        tick();
        i_valid = 1'b0; i_data = LEN'($urandom); i_mode = 1'($urandom);
        lat = 1;
        while (!o_valid && lat < LEN + 4) begin
            chk({tag, "_busy_ready"}, 32'(o_ready), 32'd0);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(o_data), 32'(exp_d));
        chk({tag, "_err"}, 32'(o_err), 32'(exp_e));
`ifdef GRAY_ERR_CNT_EN
        chk({tag, "_errcnt"}, 32'(o_err_cnt), 32'(cnt_model));
`endif
        $display("%s: mode=%0d in=%b out=%b err=%0d latency=%0d", tag, mode, d, o_data, o_err, lat);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk({tag, "_valid_after"}, 32'(o_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(o_ready), 32'd1);
`ifdef GRAY_ERR_CNT_EN
        chk("rst_errcnt", 32'(o_err_cnt), 32'd0);
`endif

        // Directed encode/decode/error words
        xact(1'b0, 4'b0101, "enc_0101");
        xact(1'b1, 4'b0111, "dec_0111");
        xact(1'b0, 4'b1000, "err_enc_1000");
        xact(1'b1, 4'b1000, "err_dec_1000");
        for (int g = 0; g < 8; g++) xact(1'b1, LEN'(g), "dec_sweep");
        for (int d = 0; d < 8; d++) xact(1'b0, LEN'(d), "enc_sweep");

        // Backpressure: result held while i_ready is low, DONE ignores new words
        i_valid = 1'b1; i_mode = 1'b0; i_data = 4'b0011;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(o_valid), 32'd1);
            chk("bp_data", 32'(o_data), 32'b0010);
            chk("bp_err", 32'(o_err), 32'd0);
            i_valid = 1'($urandom); i_mode = 1'($urandom); i_data = LEN'($urandom);
            tick();
        end
        i_valid = 1'b1; i_mode = 1'b0; i_data = 4'b1001;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("bp_release_valid", 32'(o_valid), 32'd0);
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        $display("backpressure: in=0011 held out=0010 for 5 cycles, one handshake");
`ifdef GRAY_ERR_CNT_EN
        chk("bp_errcnt", 32'(o_err_cnt), 32'(cnt_model));
`endif

        // Reset in the middle of a decode
        xact(1'b0, 4'b0011, "pre_reset_enc");
        i_valid = 1'b1; i_mode = 1'b1; i_data = 4'b0110;
        tick();
        i_valid = 1'b0;
        chk("mid_busy1_ready", 32'(o_ready), 32'd0);
        tick();
        chk("mid_busy2_ready", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_data", 32'(o_data), 32'd0);
        chk("mid_rst_err", 32'(o_err), 32'd0);
        #2;
        i_rst_n = 1'b1;
        cnt_model = 0;
        tick();
        chk("mid_release_ready", 32'(o_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("mid_no_stale", 32'(o_valid), 32'd0);
            tick();
        end
`ifdef GRAY_ERR_CNT_EN
        chk("mid_errcnt", 32'(o_err_cnt), 32'd0);
`endif
        $display("reset_mid_decode: in=0110 aborted, no output");

        // Random words against the model
        for (int r = 0; r < 40; r++) xact(1'($urandom), LEN'($urandom), "random");

`ifdef GRAY_ERR_CNT_EN
        // Error counter saturation
        for (int s = 0; s < 260; s++) xact(1'($urandom), 4'b1000 | LEN'($urandom_range(0, 7)), "sat");
        chk("sat_final", 32'(o_err_cnt), 32'd255);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
